// File: rtl/adder_pkg.sv
// Shared types for the adder operand loader: FSM state encodings and default operand width.
package adder_pkg;
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GOT_A  = 2'b01,
    ST_READY  = 2'b10,
    ST_UNUSED = 2'b11
  } state_e;
endpackage

// File: rtl/button_debouncer.sv
// Raw pushbutton -> 2-flop synchronizer -> consecutive-cycle debounce -> one-cycle press pulse.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          level_prev_q, level_prev_d;

  // Any cycle of agreement with the debounced level restarts the count.
  always_comb begin
    sync_d       = {sync_q[0], btn_raw};
    cnt_d        = '0;
    level_d      = level_q;
    level_prev_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
    end
  end

  assign press = level_q & ~level_prev_q;
endmodule

// File: rtl/adder_operand_loader.sv
// Captures operand A, then operand B plus carry-in, from DIP switches on debounced load presses;
// clear press (which wins over load) empties the captures.
module adder_operand_loader
  import adder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WIDTH           = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             cin_sw,
  input  logic             btn_load,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             cin_out,
  output logic             operands_valid,
  output logic [1:0]       state_led
);
  logic             load_p, clear_p;
  logic [WIDTH-1:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic             cin_s1_q, cin_s1_d, cin_s2_q, cin_s2_d;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d, valid_q, valid_d;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clk(clk), .rst(rst), .btn_raw(btn_load), .press(load_p)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk(clk), .rst(rst), .btn_raw(btn_clear), .press(clear_p)
  );

  always_comb begin
    sw_s1_d  = sw;
    sw_s2_d  = sw_s1_q;
    cin_s1_d = cin_sw;
    cin_s2_d = cin_s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      cin_s1_q <= 1'b0;
      cin_s2_q <= 1'b0;
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
      cin_s1_q <= cin_s1_d;
      cin_s2_q <= cin_s2_d;
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_p) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (load_p) state_d = ST_GOT_A;
        ST_GOT_A: if (load_p) state_d = ST_READY;
        ST_READY: if (load_p) state_d = ST_GOT_A;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    valid_d = (state_d == ST_READY);
    if (clear_p) begin
      a_d   = '0;
      b_d   = '0;
      cin_d = 1'b0;
    end else if (load_p) begin
      case (state_q)
        ST_IDLE:  a_d = sw_s2_q;
        ST_GOT_A: begin
          b_d   = sw_s2_q;
          cin_d = cin_s2_q;
        end
        // A third load starts a fresh pair with the new value as A.
        ST_READY: begin
          a_d   = sw_s2_q;
          b_d   = '0;
          cin_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign a_out          = a_q;
  assign b_out          = b_q;
  assign cin_out        = cin_q;
  assign operands_valid = valid_q;
  assign state_led      = state_q;
endmodule

// File: doc/adder_operand_loader.md
ADDER_OPERAND_LOADER -- requirements
Module: adder_operand_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required before a button change is accepted (range 2..65535).
REQ-002 Parameter WIDTH, default 4, operand width in bits.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sw  input  WIDTH  raw DIP-switch operand value.
REQ-006 cin_sw  input  1  raw DIP-switch carry-in.
REQ-007 btn_load  input  1  raw, bouncing pushbutton, high = pressed.
REQ-008 btn_clear  input  1  raw, bouncing pushbutton, high = pressed.
REQ-009 a_out  output  WIDTH  captured operand A, drives downstream adder input A.
REQ-010 b_out  output  WIDTH  captured operand B, drives downstream adder input B.
REQ-011 cin_out  output  1  captured carry-in, drives downstream adder carry-in.
REQ-012 operands_valid  output  1  high only when A, B and cin are all captured.
REQ-013 state_led  output  2  current FSM state encoding, for LEDs.

Function
REQ-014 sw, cin_sw, btn_load, btn_clear each SHALL pass through a 2-flop synchronizer before any use.
REQ-015 Each synchronized button SHALL be debounced: a counter counts consecutive cycles where the synchronized input differs from the debounced level; any cycle of agreement clears the counter; the debounced level toggles when the count reaches DEBOUNCE_CYCLES.
REQ-016 A raw button held stable high SHALL raise its debounced level exactly DEBOUNCE_CYCLES+2 rising edges after the first edge sampling it high; a pulse shorter than DEBOUNCE_CYCLES cycles SHALL produce no change.
REQ-017 A rising edge of a debounced level SHALL produce a one-cycle press pulse; holding the button SHALL produce exactly one pulse; release produces none.
REQ-018 FSM states: IDLE (2'b00), GOT_A (2'b01), READY (2'b10); 2'b11 unused and SHALL recover to IDLE on the next edge.
REQ-019 IDLE + load pulse -> a_out <= synchronized sw, GOT_A.
REQ-020 GOT_A + load pulse -> b_out <= synchronized sw, cin_out <= synchronized cin_sw, READY.
REQ-021 READY + load pulse -> a_out <= synchronized sw, b_out <= 0, cin_out <= 0, GOT_A (starts new operand pair).
REQ-022 Clear pulse in any state -> a_out, b_out, cin_out <= 0, IDLE.
REQ-023 Load and clear pulses in the same cycle: clear SHALL win, load is discarded.
REQ-024 Captured outputs SHALL update on the edge following the press pulse and otherwise hold regardless of sw/cin_sw changes.
REQ-025 operands_valid SHALL be 1 exactly when state is READY, registered with the state.
REQ-026 state_led SHALL equal the state encoding.

Reset
REQ-027 rst high SHALL immediately force state IDLE, a_out=0, b_out=0, cin_out=0, operands_valid=0, state_led=2'b00.
REQ-028 rst SHALL clear all synchronizer flops, debounce counters and debounced levels to 0.
REQ-029 A button held high while rst deasserts SHALL be treated as a new press after DEBOUNCE_CYCLES+2 edges.
REQ-030 Reset asserted mid-operation (any state, mid-debounce) SHALL discard all partial captures.

Structure
REQ-031 State encodings and default WIDTH SHALL live in shared package adder_pkg.
REQ-032 Debounce + synchronizer + edge pulse SHALL be sub-module button_debouncer (parameter DEBOUNCE_CYCLES), instantiated twice.
REQ-033 The FSM and capture registers SHALL reside in adder_operand_loader.

Verification (DEBOUNCE_CYCLES=4)
REQ-034 Reset, sw=3, clean load press; sw=5, cin_sw=1, clean load press -> a_out=3, b_out=5, cin_out=1, operands_valid=1, state_led=2'b10.
REQ-035 btn_load bouncing 1,0,1,1,0 then stable high 10 cycles -> exactly one capture, state IDLE->GOT_A only.
REQ-036 btn_load high 3 cycles then low -> no state change, outputs remain 0.
REQ-037 In READY, sw=9, load press -> a_out=9, b_out=0, cin_out=0, state GOT_A, operands_valid=0.
REQ-038 In GOT_A, load and clear pressed together -> state IDLE, all outputs 0.
REQ-039 rst pulsed asynchronously between clock edges while in READY -> outputs 0 immediately, before next edge.
